// File: rtl/hpdcache_sram_rmw_wbe.sv
// hpdcache_sram_rmw_wbe
//   Byte-enable emulation in front of a 1RW SRAM macro that has no byte mask.
//   Reads and full-mask writes go straight to the macro. Zero-mask writes are
//   absorbed. Partial-mask writes become read / merge / write-back, and new
//   requests are stalled until the write-back.
//   Optional build macro: HPDCACHE_SRAM_RMW_REG_EN
//     When it is defined, the merged word is registered in MERGE and written in
//     an extra WRITE state. This keeps sram_rdata off the sram_wdata path.
module hpdcache_sram_rmw_wbe #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 256,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_SIZE-1:0]   req_addr,
  input  logic [DATA_SIZE-1:0]   req_wdata,
  input  logic [DATA_SIZE/8-1:0] req_wbyteenable,
  output logic                   rsp_valid,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic                   sram_cs,
  output logic                   sram_we,
  output logic [ADDR_SIZE-1:0]   sram_addr,
  output logic [DATA_SIZE-1:0]   sram_wdata,
  input  logic [DATA_SIZE-1:0]   sram_rdata,
  output logic                   busy
);

  localparam int unsigned BE_SIZE = DATA_SIZE / 8;

  // The macro depth must match the address width; catch a bad override at elaboration
  if (DEPTH != 2**ADDR_SIZE) begin : g_depth_check
    $error("hpdcache_sram_rmw_wbe: DEPTH must equal 2**ADDR_SIZE");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [BE_SIZE-1:0]   mask_q;
  logic                 rsp_valid_q;

  logic                 cs_s, we_s;
  logic                 load_req_s, load_merge_s, rd_accept_s;
  logic [DATA_SIZE-1:0] merged_s;

  // Keep the enabled bytes from the new data and the other bytes from the old word
  function automatic logic [DATA_SIZE-1:0] merge_bytes(
    input logic [DATA_SIZE-1:0] old_data,
    input logic [DATA_SIZE-1:0] new_data,
    input logic [BE_SIZE-1:0]   mask
  );
    logic [DATA_SIZE-1:0] result;
    result = old_data;
    for (int i = 0; i < int'(BE_SIZE); i++) begin
      result[8*i +: 8] = mask[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return result;
  endfunction

  assign merged_s  = merge_bytes(sram_rdata, wdata_q, mask_q);
  assign req_ready = (state_q == ST_IDLE) && !rst;

  // Reset blocks any macro access, so a write-back in progress is dropped
  assign sram_cs   = cs_s & ~rst;
  assign sram_we   = we_s & ~rst;

  // The read response uses the macro output directly, in the cycle after the read
  assign rsp_rdata = sram_rdata;
  assign rsp_valid = rsp_valid_q & ~rst;
  assign busy      = (state_q != ST_IDLE) && !rst;

  // Next state and macro drive: taken from req_* in IDLE and from the RMW registers otherwise
  always_comb begin
    state_d      = state_q;
    cs_s         = 1'b0;
    we_s         = 1'b0;
    sram_addr    = addr_q;
    sram_wdata   = wdata_q;
    load_req_s   = 1'b0;
    load_merge_s = 1'b0;
    rd_accept_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
        if (req_valid && req_ready) begin
          if (!req_we) begin
            cs_s        = 1'b1;
            rd_accept_s = 1'b1;
          end else if (&req_wbyteenable) begin
            cs_s = 1'b1;
            we_s = 1'b1;
          end else if (req_wbyteenable == {BE_SIZE{1'b0}}) begin
            cs_s = 1'b0;
          end else begin
            cs_s       = 1'b1;
            load_req_s = 1'b1;
            state_d    = ST_MERGE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MERGE: begin
`ifdef HPDCACHE_SRAM_RMW_REG_EN
        load_merge_s = 1'b1;
        state_d      = ST_WRITE;
`else
        cs_s       = 1'b1;
        we_s       = 1'b1;
        sram_wdata = merged_s;
        state_d    = ST_IDLE;
`endif
      end
      ST_WRITE: begin
`ifdef HPDCACHE_SRAM_RMW_REG_EN
        cs_s = 1'b1;
        we_s = 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, RMW capture registers and the read-response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_SIZE{1'b0}};
      wdata_q     <= {DATA_SIZE{1'b0}};
      mask_q      <= {BE_SIZE{1'b0}};
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rd_accept_s;
      if (load_req_s) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mask_q  <= req_wbyteenable;
      end else if (load_merge_s) begin
        wdata_q <= merged_s;
      end else begin
        wdata_q <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_sram_rmw_wbe.sv
// Self-checking bench for hpdcache_sram_rmw_wbe. It includes a behavioural SRAM
// macro, a reference memory, and a scoreboard of expected read data.
module tb_hpdcache_sram_rmw_wbe;

  localparam int AW = 8;
  localparam int DW = 256;
  localparam int BW = DW / 8;
`ifdef HPDCACHE_SRAM_RMW_REG_EN
  localparam int RMW_STALL = 2;
`else
  localparam int RMW_STALL = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_wbyteenable;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          busy;
  logic          init_en;

  hpdcache_sram_rmw_wbe #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wbyteenable(req_wbyteenable),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a) ^ 8'h3C;
    return {BW{b}};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] w,
                                          input logic [BW-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < BW; i++) r[8*i +: 8] = m[i] ? w[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Behavioural 1RW macro without a byte mask; read data is registered
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q [$];
  int            n_tests = 0, n_fail = 0;
  int            pend_cnt = 0, busy_cnt = 0, cs_cnt = 0, rsp_cnt = 0;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data, last_rsp;
  logic [BW-1:0] pend_mask;
  logic          acc, cs_seen, busy_seen, rspv_seen, ready_seen;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: decide acceptance at the falling edge, then check responses #1 after the rising edge
  task automatic tick();
    @(negedge clk);
    if (pend_cnt > 0) begin
      if (rst) pend_cnt = 0;
      else begin
        pend_cnt--;
        if (pend_cnt == 0) ref_mem[pend_addr] = merge(ref_mem[pend_addr], pend_data, pend_mask);
      end
    end
    acc        = req_valid && req_ready;
    cs_seen    = sram_cs;
    busy_seen  = busy;
    rspv_seen  = rsp_valid;
    ready_seen = req_ready;
    if (busy) busy_cnt++;
    if (sram_cs) cs_cnt++;
    if (acc) begin
      if (!req_we) exp_q.push_back(ref_mem[req_addr]);
      else if (&req_wbyteenable) ref_mem[req_addr] = req_wdata;
      else if (req_wbyteenable != '0) begin
        pend_addr = req_addr; pend_data = req_wdata; pend_mask = req_wbyteenable;
        pend_cnt  = RMW_STALL;
      end
    end
    @(posedge clk);
    #1;
    if (rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) check("rsp_unexpected", DW'(1'b1), DW'(1'b0));
      else begin
        last_rsp = rsp_rdata;
        check("rsp_data", rsp_rdata, exp_q.pop_front());
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] m, output int stalls);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wbyteenable = m;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
      stalls++;
    end
    if (!acc) check("req_timeout", DW'(acc), DW'(1'b1));
    req_valid = 1'b0;
  endtask

  int st, b0, c0, r0, na;

  initial begin
    rst = 1'b1; init_en = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wbyteenable = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    tick(); tick();
    check("rst_ready", DW'(req_ready), DW'(1'b0));
    check("rst_rsp_valid", DW'(rsp_valid), DW'(1'b0));
    check("rst_cs", DW'(sram_cs), DW'(1'b0));
    check("rst_busy", DW'(busy), DW'(1'b0));
    rst = 1'b0; init_en = 1'b0;
    tick();
    check("post_rst_ready", DW'(req_ready), DW'(1'b1));

    // 1: full write then read
    do_req(1'b1, 8'h10, {BW{8'hAA}}, '1, st);
    check("t1_wr_stall", DW'(st), DW'(0));
    do_req(1'b0, 8'h10, '0, '0, st);
    check("t1_rd_stall", DW'(st), DW'(0));
    check("t1_rsp_latency", DW'(exp_q.size()), DW'(0));
    check("t1_data", last_rsp, {BW{8'hAA}});

    // 2: partial write, then read sees merge
    b0 = busy_cnt;
    do_req(1'b1, 8'h10, {BW{8'h55}}, 32'h0000_000F, st);
    do_req(1'b0, 8'h10, '0, '0, st);
    check("t2_stall", DW'(st), DW'(RMW_STALL));
    check("t2_busy", DW'(busy_cnt - b0), DW'(RMW_STALL));
    check("t2_rsp_latency", DW'(exp_q.size()), DW'(0));
    check("t2_data", last_rsp, {{28{8'hAA}}, {4{8'h55}}});

    // 3: zero-mask write makes no access
    c0 = cs_cnt;
    do_req(1'b1, 8'h20, {BW{8'hFF}}, '0, st);
    check("t3_stall", DW'(st), DW'(0));
    check("t3_cs", DW'(cs_cnt - c0), DW'(0));
    do_req(1'b0, 8'h20, '0, '0, st);
    check("t3_data", last_rsp, pat(8'h20));

    // 4: partial write, then a read held valid behind it
    c0 = cs_cnt;
    do_req(1'b1, 8'h30, {BW{8'hC3}}, 32'h8000_0001, st);
    do_req(1'b0, 8'h30, '0, '0, st);
    check("t4_stall", DW'(st), DW'(RMW_STALL));
    check("t4_cs", DW'(cs_cnt - c0), DW'(3));
    check("t4_data", last_rsp, {8'hC3, {30{8'h0C}}, 8'hC3});

    // 5: reset during the RMW drops the write-back
    do_req(1'b1, 8'h40, {BW{8'h11}}, '1, st);
    do_req(1'b1, 8'h40, {BW{8'hEE}}, 32'h0000_00F0, st);
    rst = 1'b1;
    tick();
    check("t5_cs", DW'(cs_seen), DW'(1'b0));
    check("t5_busy", DW'(busy_seen), DW'(1'b0));
    check("t5_rsp_valid", DW'(rspv_seen), DW'(1'b0));
    check("t5_ready", DW'(ready_seen), DW'(1'b0));
    tick();
    rst = 1'b0;
    tick();
    check("t5_busy_after", DW'(busy), DW'(1'b0));
    do_req(1'b0, 8'h40, '0, '0, st);
    check("t5_data", last_rsp, {BW{8'h11}});

    // 6: eight back-to-back reads
    r0 = rsp_cnt; na = 0;
    req_valid = 1'b1; req_we = 1'b0; req_wbyteenable = '0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 8'(8'h50 + i);
      tick();
      if (acc) na++;
    end
    req_valid = 1'b0;
    check("t6_accepts", DW'(na), DW'(8));
    check("t6_rsps", DW'(rsp_cnt - r0), DW'(8));
    check("t6_last", last_rsp, pat(8'h57));

    tick(); tick();
    check("sb_empty", DW'(exp_q.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
